// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main control; sequences fetch, decode,
// execute, memory and writeback states and drives datapath enables/muxes.
// Ports: clk, rst (async high), opcode, mem_ready in; PCWrite, PCWriteCond,
// IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
// ALUSrcB[1:0], PCSource[1:0], ALUOp[2:0], retire, state[3:0] out.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky
// TRAP state and an extra illegal_op output is provided.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_SLTI  = 6'b001010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       retire,
  output logic [3:0] state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  logic [3:0] next;
  logic [5:0] op_q;
  logic       op_legal;
  logic [3:0] dec_next;

  // opcode is only trusted during DECODE, so latch it on the way out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= 6'd0;
    end else begin
      state <= next;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    op_legal = 1'b1;
    dec_next = S_FETCH;
    case (opcode)
      OP_LW, OP_SW:     dec_next = S_MEMADR;
      OP_RTYPE:         dec_next = S_EXEC;
      OP_BEQ:           dec_next = S_BRANCH;
      OP_J:             dec_next = S_JUMP;
      OP_ADDI, OP_SLTI: dec_next = S_IEXEC;
      default: begin
        op_legal = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        dec_next = S_TRAP;
`else
        dec_next = S_FETCH;
`endif
      end
    endcase
  end

  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: next = dec_next;
      S_MEMADR: next = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next = S_FETCH;
      S_MEMWR:  next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next = S_RWB;
      S_RWB:    next = S_FETCH;
      S_BRANCH: next = S_FETCH;
      S_JUMP:   next = S_FETCH;
      S_IEXEC:  next = S_IWB;
      S_IWB:    next = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   next = S_TRAP;
`endif
      default:  next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 3'b011;
    retire      = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        // illegal opcode retires here as a NOP
        retire = ~op_legal;
`endif
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b000;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (op_q == OP_SLTI) ? 3'b010 : 3'b011;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
    // reset abandons the instruction: no write or request escapes
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      retire      = 1'b0;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed bench for mc_control_fsm with an expected-
// vector queue; each cycle's outputs are checked against a table model.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] JUNK     = 6'h15;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rwr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       ret;
    logic       ill;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, retire;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic       ill_obs;

  vec_t       sb[$];
  logic [5:0] iop = OP_RTYPE;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .retire(retire), .state(state)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal_op(ill_obs)
`endif
  );

`ifndef MC_CTRL_ILLEGAL_TRAP_EN
  assign ill_obs = 1'b0;
`endif

  function automatic logic legal(logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_J || op == OP_ADDI ||
           op == OP_SLTI;
  endfunction

  function automatic vec_t model(int s, logic [5:0] opq,
                                 logic [5:0] opc, logic mr, logic r);
    vec_t e;
    e = '0;
    e.st = 4'(s);
    e.aluop = 3'b011;
    case (s)
      0: begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
      1: begin
        e.srcb = 2'b11;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        e.ret = !legal(opc);
`endif
      end
      2: begin e.srca = 1; e.srcb = 2'b10; end
      3: begin e.mrd = 1; e.iord = 1; end
      4: begin e.rwr = 1; e.m2r = 1; e.ret = 1; end
      5: begin e.mwr = 1; e.iord = 1; e.ret = mr; end
      6: begin e.srca = 1; e.aluop = 3'b000; end
      7: begin e.rdst = 1; e.rwr = 1; e.ret = 1; end
      8: begin
        e.srca = 1; e.aluop = 3'b001; e.pcwc = 1;
        e.pcsrc = 2'b01; e.ret = 1;
      end
      9: begin e.pcw = 1; e.pcsrc = 2'b10; e.ret = 1; end
      10: begin
        e.srca = 1; e.srcb = 2'b10;
        e.aluop = (opq == OP_SLTI) ? 3'b010 : 3'b011;
      end
      11: begin e.rwr = 1; e.ret = 1; end
      12: e.ill = 1;
      default: ;
    endcase
    if (r) begin
      e.pcw = 0; e.pcwc = 0; e.mrd = 0; e.mwr = 0;
      e.irw = 0; e.rwr = 0; e.ret = 0;
    end
    return e;
  endfunction

  function automatic vec_t sample();
    vec_t g;
    g.st = state; g.pcw = PCWrite; g.pcwc = PCWriteCond;
    g.iord = IorD; g.mrd = MemRead; g.mwr = MemWrite;
    g.irw = IRWrite; g.m2r = MemtoReg; g.rdst = RegDst;
    g.rwr = RegWrite; g.srca = ALUSrcA; g.srcb = ALUSrcB;
    g.pcsrc = PCSource; g.aluop = ALUOp; g.ret = retire;
    g.ill = ill_obs;
    return g;
  endfunction

  task automatic check(string tag);
    vec_t e;
    vec_t g;
    e = sb.pop_front();
    g = sample();
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, g, e);
    end
  endtask

  // one cycle: drive at negedge, queue expectation, check before posedge
  task automatic cyc(int s, logic mr, logic r, string tag);
    @(negedge clk);
    rst = r;
    mem_ready = mr;
    opcode = (s == 1) ? iop : JUNK;
    sb.push_back(model(s, iop, opcode, mr, r));
    #1 check(tag);
  endtask

  initial begin
    cyc(0, 1, 1, "reset0");
    cyc(0, 1, 1, "reset1");

    iop = OP_RTYPE;
    cyc(0, 1, 0, "r_fetch");
    cyc(1, 1, 0, "r_dec");
    cyc(6, 1, 0, "r_exec");
    cyc(7, 1, 0, "r_wb");

    iop = OP_LW;
    cyc(0, 1, 0, "lw_fetch");
    cyc(1, 1, 0, "lw_dec");
    cyc(2, 1, 0, "lw_adr");
    cyc(3, 0, 0, "lw_rd_w0");
    cyc(3, 0, 0, "lw_rd_w1");
    cyc(3, 1, 0, "lw_rd");
    cyc(4, 1, 0, "lw_wb");

    iop = OP_BEQ;
    cyc(0, 1, 0, "beq_fetch");
    cyc(1, 1, 0, "beq_dec");
    cyc(8, 1, 0, "beq_br");

    iop = OP_SLTI;
    cyc(0, 1, 0, "slti_fetch");
    cyc(1, 1, 0, "slti_dec");
    cyc(10, 1, 0, "slti_ex");
    cyc(11, 1, 0, "slti_wb");

    iop = OP_ADDI;
    cyc(0, 1, 0, "addi_fetch");
    cyc(1, 1, 0, "addi_dec");
    cyc(10, 1, 0, "addi_ex");
    cyc(11, 1, 0, "addi_wb");

    iop = OP_J;
    cyc(0, 1, 0, "j_fetch");
    cyc(1, 1, 0, "j_dec");
    cyc(9, 1, 0, "j_jump");

    iop = OP_SW;
    cyc(0, 0, 0, "sw_fw0");
    cyc(0, 0, 0, "sw_fw1");
    cyc(0, 0, 0, "sw_fw2");
    cyc(0, 1, 0, "sw_fetch");
    cyc(1, 1, 0, "sw_dec");
    cyc(2, 1, 0, "sw_adr");
    cyc(5, 0, 0, "sw_wr_w");
    cyc(5, 1, 0, "sw_wr");

    cyc(0, 1, 0, "sw2_fetch");
    cyc(1, 1, 0, "sw2_dec");
    cyc(2, 1, 0, "sw2_adr");
    cyc(5, 0, 0, "sw2_wr_w");
    #2 rst = 1'b1;
    sb.push_back(model(0, iop, opcode, mem_ready, 1'b1));
    #1 check("rst_async");
    cyc(0, 1, 1, "rst_hold");
    iop = OP_RTYPE;
    cyc(0, 1, 0, "rel_fetch");
    cyc(1, 1, 0, "rel_dec");
    cyc(6, 1, 0, "rel_exec");
    cyc(7, 1, 0, "rel_wb");

    iop = 6'b111111;
    cyc(0, 1, 0, "ill_fetch");
    cyc(1, 1, 0, "ill_dec");
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) cyc(12, 1, 0, "ill_trap");
    cyc(0, 1, 1, "ill_reset");
`else
    cyc(0, 1, 0, "ill_nop_fetch");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
